ifetch_mt: RTL
==============

# ifetch_mt

Parametrised multi-context instruction fetch unit. It keeps one program counter per (channel, thread) context and accepts task grants from the scheduler. For each grant it pushes one fetch request into the instruction FIFO. It tracks outstanding fetches per context and tags every request with a per-context jump epoch, so that downstream logic can discard fetches made stale by a jump.

## Interface
Parameters:
- CHANNELS, 8, number of channels; CH_W = max(1, clog2(CHANNELS))
- THREADS, 2, threads per channel; TH_W = max(1, clog2(THREADS))
- PC_W, 12, program counter width
- ADDR_W, 16, fetch address width (≥ PC_W)
- CODE_BASE, 16'h8000, base added to PC to form the fetch address
- REQ_OP, 5'h02, opcode field placed in every FIFO word
- RESET_PC, 0, reset value of every context PC
- MAX_OUT, 2, maximum outstanding fetches per context (1..7)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- next_task_ready  in  1  scheduler offers a context
- next_task_channel  in  CH_W  offered channel
- next_task_thread  in  TH_W  offered thread
- next_task_ack  out  1  combinational; offer accepted at this edge
- ififo_full  in  1  instruction FIFO cannot accept a word
- ififo_shift  out  1  registered push strobe
- ififo_di  out  5+CH_W+TH_W+1+ADDR_W  registered {REQ_OP, channel, thread, epoch, address}
- fetch_done  in  1  one fetch has completed
- fetch_done_channel / fetch_done_thread  in  CH_W / TH_W  context of the completed fetch
- jump_enable  in  1  load a new PC
- jump_channel / jump_thread  in  CH_W / TH_W  target context
- jump_target  in  PC_W  new PC
- current_pc  out  PC_W  registered; PC of the most recently issued or jumped context

## Operation
- Context index = {channel, thread}. Per-context state: pc[PC_W], epoch[1], outstanding[3].
- FSM with two states:
  - IDLE: next_task_ack = next_task_ready & (outstanding[ctx] < MAX_OUT) & reset_n. On ack, the context is latched and the FSM moves to ISSUE.
  - ISSUE, ififo_full=1: the FSM stays in ISSUE and ififo_shift stays 0.
  - ISSUE, ififo_full=0: register ififo_shift=1 and ififo_di = {REQ_OP, ch, th, epoch, CODE_BASE + zero-extended pc} (mod 2^ADDR_W). Then pc ← pc+1 (wraps mod 2^PC_W), outstanding++, current_pc ← pre-increment pc, return to IDLE.
- ififo_shift is high for exactly one cycle per issue. ififo_di holds its last value while shift is 0.
- Jump: pc[ctx] ← jump_target, epoch[ctx] toggles, current_pc ← jump_target. Outstanding is not cleared, because stale fetches still return fetch_done.
- fetch_done: outstanding[ctx]-- and saturates at 0. A done for a context with 0 outstanding is ignored.
- Unknown contexts (index ≥ CHANNELS*THREADS):
  - offers are never acked;
  - jumps and dones to them are ignored.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - state IDLE;
  - all pc = RESET_PC, all epoch = 0, all outstanding = 0;
  - ififo_shift = 0, ififo_di = 0, current_pc = RESET_PC.
  - next_task_ack is forced to 0 while reset_n=0.
- Reset mid-ISSUE abandons the request. No shift follows the release of reset.
- Latency: offer accepted at edge E1; with ififo_full=0 at E2, ififo_shift is high from E2 to E3.
- Jump takes effect at the sampling edge; new values are visible the following cycle.
- Simultaneous events:
  - Jump and issue to the same latched context in the same cycle: the jump wins. The issue is cancelled (shift=0, pc and outstanding unchanged, FSM returns to IDLE), and current_pc = jump_target.
  - Jump to a different context during an issue: both take effect.
  - Issue and fetch_done on the same context: outstanding is unchanged (net 0).
  - Jump in IDLE to the context being offered: the ack is still granted. The subsequent issue uses the new pc and new epoch.
- No combinational path from ififo_full to ififo_shift.

## Test plan
(Default parameters. ififo_di width is 26.)
- After reset, offer ch3/th0 → ack for 1 cycle. Two edges later shift=1 for one cycle with di = {5'h02, 3'd3, 1'b0, 1'b0, 16'h8000}. A second offer of the same context → address 16'h8001.
- Jump ch3/th0 to 12'h555 → next cycle current_pc=12'h555 and shift=0. The next issue carries epoch=1 and address 16'h8555.
- Hold ififo_full=1 for 3 cycles in ISSUE → shift stays 0. Exactly one shift occurs, in the cycle after full drops.
- Two issues on ch5/th1 with no fetch_done → a third offer is not acked. Pulse fetch_done for ch5/th1 → the offer is acked next cycle. A done when outstanding is 0 leaves the count at 0.
- Jump to 12'hFFF and issue twice → addresses 16'h8FFF then 16'h8000 (pc wraps to 0).
- Assert reset_n=0 during ISSUE with ififo_full=1, then release → shift stays 0, current_pc=0, and the next offer of any context fetches 16'h8000 with epoch 0.

Source files
------------

// File: rtl/ifetch_mt.sv
// Multi-context instruction fetch unit: one PC, jump epoch and outstanding-fetch
// counter per (channel, thread) context; each accepted grant pushes one fetch word.
module ifetch_mt #(
  parameter int                 CHANNELS  = 8,
  parameter int                 THREADS   = 2,
  parameter int                 PC_W      = 12,
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  CODE_BASE = 16'h8000,
  parameter logic [4:0]         REQ_OP    = 5'h02,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter int                 MAX_OUT   = 2,
  localparam int                CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int                TH_W      = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int                DI_W      = 5 + CH_W + TH_W + 1 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              next_task_ready,
  input  logic [CH_W-1:0]   next_task_channel,
  input  logic [TH_W-1:0]   next_task_thread,
  output logic              next_task_ack,
  input  logic              ififo_full,
  output logic              ififo_shift,
  output logic [DI_W-1:0]   ififo_di,
  input  logic              fetch_done,
  input  logic [CH_W-1:0]   fetch_done_channel,
  input  logic [TH_W-1:0]   fetch_done_thread,
  input  logic              jump_enable,
  input  logic [CH_W-1:0]   jump_channel,
  input  logic [TH_W-1:0]   jump_thread,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   current_pc
);

  localparam int               IDX_W     = CH_W + TH_W;
  localparam int               NCTX      = 1 << IDX_W;
  localparam logic [IDX_W:0]   NUM_CTX   = (IDX_W + 1)'(CHANNELS * THREADS);
  localparam logic [2:0]       MAX_OUT_C = 3'(MAX_OUT);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ctx_reg;
  logic               shift_reg;
  logic [DI_W-1:0]    di_reg;
  logic [PC_W-1:0]    cur_pc_reg;

  logic [PC_W-1:0]    pc_arr    [NCTX];
  logic               epoch_arr [NCTX];
  logic [2:0]         out_arr   [NCTX];

  logic [IDX_W-1:0]   offer_idx, jump_idx, done_idx;
  logic               offer_ok, jump_ok, done_ok, jump_same;
  logic               issue_fire;
  logic [ADDR_W-1:0]  issue_addr;

  assign offer_idx = {next_task_channel, next_task_thread};
  assign jump_idx  = {jump_channel, jump_thread};
  assign done_idx  = {fetch_done_channel, fetch_done_thread};

  // Indices past the populated context range are silently dropped.
  assign offer_ok  = next_task_ready && reset_n && ({1'b0, offer_idx} < NUM_CTX)
                     && (out_arr[offer_idx] < MAX_OUT_C);
  assign jump_ok   = jump_enable && ({1'b0, jump_idx} < NUM_CTX);
  assign done_ok   = fetch_done && ({1'b0, done_idx} < NUM_CTX);
  assign jump_same = jump_ok && (jump_idx == ctx_reg);

  assign issue_addr = CODE_BASE + ADDR_W'(pc_arr[ctx_reg]);

  always_comb begin
    state_next    = state_reg;
    next_task_ack = 1'b0;
    issue_fire    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (offer_ok) begin
          next_task_ack = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        // A jump to the latched context cancels the push but still frees the FSM.
        if (!ififo_full) begin
          issue_fire = !jump_same;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ctx_reg    <= '0;
      shift_reg  <= 1'b0;
      di_reg     <= '0;
      cur_pc_reg <= RESET_PC;
    end else begin
      state_reg <= state_next;
      shift_reg <= issue_fire;
      if (next_task_ack) ctx_reg <= offer_idx;
      if (issue_fire) di_reg <= {REQ_OP, ctx_reg, epoch_arr[ctx_reg], issue_addr};
      // When a jump lands on another context during an issue, the jump target is reported.
      if (jump_ok)         cur_pc_reg <= jump_target;
      else if (issue_fire) cur_pc_reg <= pc_arr[ctx_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCTX; gi++) begin : g_ctx
      localparam logic [IDX_W-1:0] ME = IDX_W'(gi);
      logic [PC_W-1:0] pc_reg;
      logic            epoch_reg;
      logic [2:0]      out_reg;
      logic            jump_hit, issue_hit, done_hit;

      assign jump_hit  = jump_ok && (jump_idx == ME);
      assign issue_hit = issue_fire && (ctx_reg == ME);
      assign done_hit  = done_ok && (done_idx == ME);

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          pc_reg    <= RESET_PC;
          epoch_reg <= 1'b0;
          out_reg   <= 3'd0;
        end else begin
          if (jump_hit) begin
            pc_reg    <= jump_target;
            epoch_reg <= ~epoch_reg;
          end else if (issue_hit) begin
            pc_reg <= pc_reg + PC_W'(1);
          end
          // Issue and completion on the same context cancel out.
          if (issue_hit && !done_hit)
            out_reg <= out_reg + 3'd1;
          else if (!issue_hit && done_hit && (out_reg != 3'd0))
            out_reg <= out_reg - 3'd1;
        end
      end

      assign pc_arr[gi]    = pc_reg;
      assign epoch_arr[gi] = epoch_reg;
      assign out_arr[gi]   = out_reg;
    end
  endgenerate

  assign ififo_shift = shift_reg;
  assign ififo_di    = di_reg;
  assign current_pc  = cur_pc_reg;

endmodule
